// File: rtl/bit_pkg.sv
// Shared types and helpers for the single-bit input conditioning path
// (bit_sync -> bit_debounce).
package bit_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } bit_deb_state_t;

  // Counter width for an N-sample qualifier: max(1, clog2(n)).
  function automatic int cnt_width(int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_debounce.sv
// Debounces a synchronized level: a change is accepted only after it has held for
// STABLE_CYCLES consecutive samples, then bit_o updates with a one-cycle edge pulse.
module bit_debounce
  import bit_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic INIT_VAL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic bit_i,
  output logic bit_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bit_deb_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= INIT_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      STABLE: begin
        if (bit_i == level_q) begin
          cnt_d = '0;
        end else if (STABLE_CYCLES == 1) begin
          accept = 1'b1;
        end else begin
          state_d = PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      PENDING: begin
        if (bit_i == level_q) begin
          // Candidate collapsed before qualifying: treat as a glitch.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    // Pulses come from the accept itself so they line up with the level update.
    if (accept) begin
      level_d = bit_i;
      rise_d  = bit_i;
      fall_d  = ~bit_i;
      state_d = STABLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bit_o  = level_q;
    rise_o = rise_q;
    fall_o = fall_q;
    busy_o = (state_q == PENDING);
  end

endmodule

// File: tb/tb_bit_debounce.sv
// Directed bench for bit_debounce: N=4 and N=1 instances, hand-derived expected
// {bit_o, rise_o, fall_o, busy_o} per cycle, queued at drive time and popped at sample time.
module tb_bit_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic in4, in1;
  logic bit4, rise4, fall4, busy4;
  logic bit1, rise1, fall1, busy1;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bit_debounce #(.STABLE_CYCLES(4), .INIT_VAL(1'b0)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .bit_i(in4),
    .bit_o(bit4), .rise_o(rise4), .fall_o(fall4), .busy_o(busy4)
  );

  bit_debounce #(.STABLE_CYCLES(1), .INIT_VAL(1'b0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bit_i(in1),
    .bit_o(bit1), .rise_o(rise1), .fall_o(fall1), .busy_o(busy1)
  );

  task automatic push_exp(input logic [3:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [3:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %b required an entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed {bit,rise,fall,busy}=%b required %b", e.tag, obs, e.v);
    end
  endtask

  // One clock of N=4 stimulus: drive on the falling edge, sample just after the rising edge.
  task automatic step4(input logic b, input logic [3:0] e, input string tag);
    @(negedge clk);
    in4 = b;
    push_exp(e, tag);
    @(posedge clk);
    #1;
    pop_check({bit4, rise4, fall4, busy4});
  endtask

  task automatic step1(input logic b, input logic [3:0] e, input string tag);
    @(negedge clk);
    in1 = b;
    push_exp(e, tag);
    @(posedge clk);
    #1;
    pop_check({bit1, rise1, fall1, busy1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in4   = 1'b1;
    in1   = 1'b0;

    // Reset held with input already high: outputs must sit at reset values.
    repeat (2) @(posedge clk);
    #1;
    push_exp(4'b0000, "reset_n4");
    pop_check({bit4, rise4, fall4, busy4});
    push_exp(4'b0000, "reset_n1");
    pop_check({bit1, rise1, fall1, busy1});
    rst_n = 1'b1;

    // After release the high input is qualified normally: rise on the 4th sample.
    step4(1'b1, 4'b0001, "post_reset_s1");
    step4(1'b1, 4'b0001, "post_reset_s2");
    step4(1'b1, 4'b0001, "post_reset_s3");
    step4(1'b1, 4'b1100, "post_reset_rise");
    step4(1'b1, 4'b1000, "post_reset_hold");

    // Fall from bit_o=1.
    step4(1'b0, 4'b1001, "fall_s1");
    step4(1'b0, 4'b1001, "fall_s2");
    step4(1'b0, 4'b1001, "fall_s3");
    step4(1'b0, 4'b0010, "fall_pulse");
    step4(1'b0, 4'b0000, "fall_hold");

    // Clean rise held for 10 cycles.
    step4(1'b1, 4'b0001, "rise_s1");
    step4(1'b1, 4'b0001, "rise_s2");
    step4(1'b1, 4'b0001, "rise_s3");
    step4(1'b1, 4'b1100, "rise_pulse");
    for (int i = 0; i < 6; i++) step4(1'b1, 4'b1000, "rise_hold");
    step4(1'b0, 4'b1001, "back_s1");
    step4(1'b0, 4'b1001, "back_s2");
    step4(1'b0, 4'b1001, "back_s3");
    step4(1'b0, 4'b0010, "back_fall");

    // Glitch of 3 samples is rejected.
    step4(1'b1, 4'b0001, "glitch_s1");
    step4(1'b1, 4'b0001, "glitch_s2");
    step4(1'b1, 4'b0001, "glitch_s3");
    step4(1'b0, 4'b0000, "glitch_drop");
    step4(1'b0, 4'b0000, "glitch_idle");

    // Bounce 1,0,1,1,0,1,1,1,1: only the final 4-sample run qualifies.
    step4(1'b1, 4'b0001, "bounce_1");
    step4(1'b0, 4'b0000, "bounce_0a");
    step4(1'b1, 4'b0001, "bounce_1a");
    step4(1'b1, 4'b0001, "bounce_1b");
    step4(1'b0, 4'b0000, "bounce_0b");
    step4(1'b1, 4'b0001, "bounce_run1");
    step4(1'b1, 4'b0001, "bounce_run2");
    step4(1'b1, 4'b0001, "bounce_run3");
    step4(1'b1, 4'b1100, "bounce_rise");
    step4(1'b1, 4'b1000, "bounce_hold");
    step4(1'b0, 4'b1001, "ret_s1");
    step4(1'b0, 4'b1001, "ret_s2");
    step4(1'b0, 4'b1001, "ret_s3");
    step4(1'b0, 4'b0010, "ret_fall");

    // Async reset after two qualifying samples.
    step4(1'b1, 4'b0001, "mid_s1");
    step4(1'b1, 4'b0001, "mid_s2");
    rst_n = 1'b0;
    #1;
    push_exp(4'b0000, "mid_reset_async");
    pop_check({bit4, rise4, fall4, busy4});
    @(posedge clk);
    #1;
    push_exp(4'b0000, "mid_reset_held");
    pop_check({bit4, rise4, fall4, busy4});
    rst_n = 1'b1;
    step4(1'b1, 4'b0001, "restart_s1");
    step4(1'b1, 4'b0001, "restart_s2");
    step4(1'b1, 4'b0001, "restart_s3");
    step4(1'b1, 4'b1100, "restart_rise");
    step4(1'b1, 4'b1000, "restart_hold");

    // N=1: bit_o follows bit_i one cycle later, pulse on every change, never busy.
    step1(1'b0, 4'b0000, "n1_idle");
    step1(1'b1, 4'b1100, "n1_rise_a");
    step1(1'b0, 4'b0010, "n1_fall_a");
    step1(1'b1, 4'b1100, "n1_rise_b");
    step1(1'b0, 4'b0010, "n1_fall_b");
    step1(1'b1, 4'b1100, "n1_rise_c");
    step1(1'b1, 4'b1000, "n1_hold");
    step1(1'b0, 4'b0010, "n1_fall_c");
    step1(1'b0, 4'b0000, "n1_idle_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bit_debounce.md
# bit_debounce

Debounces and edge-qualifies a single-bit level already brought into the local clock domain by `bit_sync`. A change on the input is accepted only after it has held for `STABLE_CYCLES` consecutive clock samples. On acceptance the block updates the debounced level and emits a one-cycle rise or fall pulse. It sits directly downstream of `bit_sync`, whose `bit_o` drives this block's `bit_i`.

## Interface
- `STABLE_CYCLES`, default 4: consecutive mismatching samples required to accept a change; legal range ≥1.
- `INIT_VAL`, default 1'b0: reset value of the debounced level.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `bit_i`  in  1  synchronized input level (from `bit_sync.bit_o`); no further synchronization inside.
- `bit_o`  out  1  debounced level, registered.
- `rise_o`  out  1  one-cycle pulse, high in the cycle `bit_o` goes 0→1.
- `fall_o`  out  1  one-cycle pulse, high in the cycle `bit_o` goes 1→0.
- `busy_o`  out  1  high while a candidate change is being qualified (state PENDING).

## Operation
- Reset values: `bit_o`=INIT_VAL, `rise_o`=0, `fall_o`=0, `busy_o`=0, counter=0, state=STABLE.
- The counter width is max(1, $clog2(STABLE_CYCLES)) bits. The counter never exceeds STABLE_CYCLES-1; no wrap.
- STABLE state:
  - `bit_i`==`bit_o`: stay, counter=0.
  - `bit_i`!=`bit_o` and STABLE_CYCLES==1: accept immediately (see accept).
  - `bit_i`!=`bit_o` otherwise: go to PENDING, counter=1.
- PENDING state:
  - `bit_i`==`bit_o` (glitch): return to STABLE, counter=0, no pulse.
  - `bit_i`!=`bit_o` and counter==STABLE_CYCLES-1: accept.
  - Otherwise: counter+1.
- Accept (registered):
  - `bit_o`<=`bit_i`.
  - `rise_o`<=`bit_i`; `fall_o`<=~`bit_i`.
  - State=STABLE, counter=0.
- `rise_o` and `fall_o` are cleared on every non-accept cycle. They are never both high.
- `busy_o` = (state==PENDING), derived combinationally from the state register.
- Reset mid-PENDING: the candidate is discarded and the outputs return to their reset values asynchronously. No pulse is emitted on reset release, even if `bit_i`!=INIT_VAL; that case is qualified normally afterwards.

## Timing
- A change first sampled at edge E1 that holds through edges E1..EN (N=STABLE_CYCLES) updates `bit_o` after EN. Latency is N cycles from first sample.
- The rise/fall pulse is coincident with the `bit_o` transition and lasts exactly one cycle.
- A pulse of `bit_i` lasting fewer than N samples never reaches `bit_o`.
- Back-to-back accepted changes are spaced at least N cycles apart.
- With N=1, `bit_o` is `bit_i` delayed one cycle, with a pulse on every change.
- End-to-end latency from the raw asynchronous pin equals the `bit_sync` latency plus N.

## Structure
- The shared package `bit_pkg` holds the state typedef `bit_deb_state_t` {STABLE, PENDING}.
- The package also holds the counter-width function `cnt_width(int n)`.
- Single module with no sub-module. The edge pulses are produced in the accept branch, not by a separate edge detector, so they align with `bit_o` exactly.
- Top-level user: `bit_sync` → `bit_debounce`.

## Test plan
- **Reset:** hold `rst_n_i`=0 with `bit_i`=1, then release → `bit_o`=0, `rise_o`/`fall_o`/`busy_o`=0 during reset. After release, `bit_o` rises exactly 4 cycles later with one `rise_o` pulse.
- **Clean rise (N=4, INIT_VAL=0):** `bit_i` 0→1 held for 10 cycles → `busy_o` high for 3 cycles. `bit_o`=1 and `rise_o`=1 for one cycle after the 4th sample.
- **Glitch rejection:** `bit_i` high for 3 cycles, then low → `bit_o` stays 0, no pulses, `busy_o` drops back to 0.
- **Bounce then settle:** `bit_i` pattern 1,0,1,1,0,1,1,1,1 → a single `rise_o`, emitted after the final 4-sample run. Exactly one pulse total.
- **Fall and N=1 variant:**
  - N=4, from `bit_o`=1, `bit_i` held 0 → `fall_o` pulse, `bit_o`=0 after 4 cycles.
  - N=1, toggle `bit_i` every cycle → `bit_o` tracks with 1-cycle delay, with alternating rise/fall pulses.
- **Async reset mid-PENDING:** assert `rst_n_i` after 2 qualifying samples → outputs return to reset values immediately. No pulse is emitted, and the counter restarts from 0 after release.
